// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: register-file write source and
// load access size.
package wb_pkg;

    typedef enum logic [1:0] {
        WBSEL_ALU    = 2'b00,
        WBSEL_MEM    = 2'b01,
        WBSEL_RETURN = 2'b10,
        WBSEL_RSVD   = 2'b11
    } wbsel_e;

    typedef enum logic [1:0] {
        LOAD_BYTE     = 2'b00,
        LOAD_HALF     = 2'b01,
        LOAD_WORD     = 2'b10,
        LOAD_WORD_ALT = 2'b11
    } loadsize_e;

    localparam int unsigned MIN_DATA_WIDTH = 32;

endpackage

// File: rtl/writeback_unit_load_extend.sv
// Sub-word load extraction: picks a little-endian byte/half/word lane out of
// the low 32 bits of the read word and sign- or zero-extends it.
module load_extend
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_dataread,
    input  logic [1:0]            i_offset,
    input  logic [1:0]            i_loadsize,
    input  logic                  i_loadsigned,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [31:0] word;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        word = i_dataread[31:0];
        byte_lane = word[7:0];
        case (i_offset)
            2'd0: byte_lane = word[7:0];
            2'd1: byte_lane = word[15:8];
            2'd2: byte_lane = word[23:16];
            2'd3: byte_lane = word[31:24];
            default: byte_lane = word[7:0];
        endcase
        // Half lane ignores offset bit 0: misaligned halves read the aligned lane.
        half_lane = i_offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        o_data = '0;
        case (loadsize_e'(i_loadsize))
            LOAD_BYTE: begin
                o_data = {DATA_WIDTH{i_loadsigned & byte_lane[7]}};
                o_data[7:0] = byte_lane;
            end
            LOAD_HALF: begin
                o_data = {DATA_WIDTH{i_loadsigned & half_lane[15]}};
                o_data[15:0] = half_lane;
            end
            default: begin
                o_data = {DATA_WIDTH{i_loadsigned & word[31]}};
                o_data[31:0] = word;
            end
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// MEM/WB pipeline register plus write-value selection, stall/flush handling,
// sticky halt and a saturating retired-instruction counter.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned COUNT_WIDTH    = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_valid,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic [DATA_WIDTH-1:0]     i_dataread,
    input  logic [DATA_WIDTH-1:0]     i_address,
    input  logic [DATA_WIDTH-1:0]     i_return_address,
    input  logic [1:0]                i_wbsel,
    input  logic [1:0]                i_loadsize,
    input  logic                      i_loadsigned,
    input  logic                      i_regwrite,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd,
    input  logic                      i_halt,
    output logic                      o_regwrite,
    output logic [REG_ADDR_WIDTH-1:0] o_rd,
    output logic [DATA_WIDTH-1:0]     o_wbdata,
    output logic [COUNT_WIDTH-1:0]    o_retired,
    output logic                      o_halted
);

    logic [DATA_WIDTH-1:0]     load_data;
    logic [DATA_WIDTH-1:0]     sel_data;

    logic                      regwrite_q, regwrite_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0]     wbdata_q, wbdata_d;
    logic [COUNT_WIDTH-1:0]    retired_q, retired_d;
    logic                      halted_q, halted_d;

    load_extend #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_extend (
        .i_dataread   (i_dataread),
        .i_offset     (i_address[1:0]),
        .i_loadsize   (i_loadsize),
        .i_loadsigned (i_loadsigned),
        .o_data       (load_data)
    );

    always_comb begin
        sel_data = i_address;
        case (wbsel_e'(i_wbsel))
            WBSEL_MEM:    sel_data = load_data;
            WBSEL_RETURN: sel_data = i_return_address;
            default:      sel_data = i_address;
        endcase
    end

    // Priority: halted > stall > flush > load; reset is handled in the flop.
    always_comb begin
        regwrite_d = regwrite_q;
        rd_d       = rd_q;
        wbdata_d   = wbdata_q;
        retired_d  = retired_q;
        halted_d   = halted_q;

        if (halted_q || (!i_stall && i_flush)) begin
            regwrite_d = 1'b0;
            rd_d       = '0;
            wbdata_d   = '0;
        end else if (!i_stall) begin
            regwrite_d = i_valid & i_regwrite & ~i_halt & (i_rd != '0);
            rd_d       = i_rd;
            wbdata_d   = sel_data;
            if (i_valid && (retired_q != '1)) begin
                retired_d = retired_q + COUNT_WIDTH'(1);
            end
            if (i_valid && i_halt) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wbdata_q   <= '0;
            retired_q  <= '0;
            halted_q   <= 1'b0;
        end else begin
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wbdata_q   <= wbdata_d;
            retired_q  <= retired_d;
            halted_q   <= halted_d;
        end
    end

    assign o_regwrite = regwrite_q;
    assign o_rd       = rd_q;
    assign o_wbdata   = wbdata_q;
    assign o_retired  = retired_q;
    assign o_halted   = halted_q;

endmodule
